// File: rtl/muxf8_scan_ctl.sv
// 8-way scan controller: steps a registered select S across a downstream mux tree,
// captures each selected bit through a one-stage pipeline and publishes the word on Q.
module muxf8_scan_ctl #(
    parameter logic       INIT  = 1'b0,
    parameter logic [7:0] QINIT = 8'h00
) (
    input  logic       C,
    input  logic       CLR,
    input  logic       CE,
    input  logic       START,
    input  logic [7:0] D,
    output logic [2:0] S,
    output logic       LO,
    output logic [7:0] Q,
    output logic       BUSY,
    output logic       DONE
);

    // IDLE wait | SCAN step S 0..7 | DRAIN fold last bit into Q | DONE one-cycle pulse
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_start;
    logic [2:0] r_s;
    logic       r_lo;
    logic [6:0] r_cap;
    logic [2:0] r_idx;
    logic       r_vld;
    logic [7:0] r_q;

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            r_state <= ST_IDLE;
        end else if (CE) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_nxt = ST_SCAN;
                    w_start     = 1'b1;
                end
            end
            ST_SCAN: begin
                if (r_s == 3'd7) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (START) begin
                    w_state_nxt = ST_SCAN;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // LO lags S by one edge, so CAP is written from LO using the index S had one edge earlier.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            r_s   <= 3'd0;
            r_lo  <= INIT;
            r_cap <= 7'd0;
            r_idx <= 3'd0;
            r_vld <= 1'b0;
            r_q   <= QINIT;
        end else if (CE) begin
            if (w_start) begin
                r_s   <= 3'd0;
                r_vld <= 1'b0;
            end else if (r_state == ST_SCAN) begin
                r_lo <= D[r_s];
                if (r_vld) begin
                    r_cap[r_idx] <= r_lo;
                end
                r_idx <= r_s;
                r_vld <= 1'b1;
                if (r_s != 3'd7) begin
                    r_s <= r_s + 3'd1;
                end
            end else if (r_state == ST_DRAIN) begin
                r_q   <= {r_lo, r_cap};
                r_s   <= 3'd0;
                r_vld <= 1'b0;
            end
        end
    end

    assign S    = r_s;
    assign LO   = r_lo;
    assign Q    = r_q;
    assign BUSY = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
    assign DONE = (r_state == ST_DONE);

endmodule

// File: doc/muxf8_scan_ctl.md
MUXF8_SCAN_CTL -- requirements
Module: muxf8_scan_ctl

Interface
REQ-001 SHALL have parameter INIT, default 1'b0, reset value of LO.
REQ-002 SHALL have parameter QINIT, default 8'h00, reset value of Q.
REQ-003 SHALL have port C  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port CLR  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port CE  input  1  clock enable; CE=0 holds every register.
REQ-006 SHALL have port START  input  1  request one 8-way scan.
REQ-007 SHALL have port D  input  8  scan sources; D[i] is the mux input selected when S=i.
REQ-008 SHALL have port S  output  3  registered select code driven to the downstream 2:1 mux tree.
REQ-009 SHALL have port LO  output  1  registered mux result, D[S] sampled one edge earlier.
REQ-010 SHALL have port Q  output  8  assembled scan word, updated only on scan completion.
REQ-011 SHALL have port BUSY  output  1  high in SCAN and DRAIN.
REQ-012 SHALL have port DONE  output  1  high for exactly the DONE-state cycle.

Function
REQ-013 SHALL implement states IDLE, SCAN, DRAIN, DONE, all registered.
REQ-014 IDLE: START=1 and CE=1 at an edge SHALL go to SCAN with S=0.
REQ-015 SCAN: each enabled edge SHALL load LO <= D[S], write CAP[IDX] <= LO when pipeline-valid, and advance S by 1.
REQ-016 SCAN: the enabled edge with S=7 SHALL load LO <= D[7], go to DRAIN, and leave S at 7.
REQ-017 DRAIN: the next enabled edge SHALL load Q <= {LO, CAP[6:0]} and go to DONE.
REQ-018 DONE: START=1 SHALL go to SCAN with S=0; otherwise go to IDLE.
REQ-019 Pipeline SHALL track a delayed index IDX and valid bit, so CAP[i] always holds D[i] as sampled at the edge where S=i.
REQ-020 Timing SHALL be as follows, with START sampled at enabled edge k and CE=1 throughout:
  - S=i after edge k+i;
  - LO=D[i] after edge k+1+i;
  - Q valid and DONE=1 after edge k+9, for one cycle;
  - BUSY=1 after edges k through k+8.
REQ-021 START SHALL be ignored in SCAN and DRAIN; no restart or queuing.
REQ-022 A back-to-back START sampled in DONE SHALL begin a new scan with no idle gap; DONE SHALL deassert at that edge.
REQ-023 CE=0 SHALL freeze state, S, LO, CAP, Q, BUSY and DONE, including mid-scan and during the DONE pulse.
REQ-024 S SHALL be 0 in IDLE and DONE unless a scan is starting.
REQ-025 Q SHALL hold its value between completions.
REQ-026 Q SHALL not change during SCAN or DRAIN.
REQ-027 LO SHALL hold its last value in IDLE and DONE.
REQ-028 Changes on D SHALL affect only the bit sampled at the current S.
REQ-029 No output SHALL depend combinationally on any input.

Reset
REQ-030 CLR=1 SHALL immediately, without a clock:
  - force IDLE, S=0, LO=INIT, CAP=0, Q=QINIT, BUSY=0, DONE=0.
REQ-031 CLR asserted mid-scan SHALL abort the scan with no DONE pulse and Q=QINIT.
REQ-032 CLR SHALL take priority over CE and START.
REQ-033 On the first enabled edge after CLR release, START=1 SHALL start a scan normally.

Verification
REQ-034 Basic scan: CLR pulse, CE=1, D=8'hA5 static, START one cycle:
  - S steps 0..7;
  - BUSY high 9 cycles;
  - DONE one cycle, 9 edges after START;
  - Q=8'hA5.
REQ-035 Per-slot sampling: D changes so that D[i] is 1 only during the cycle S=i, otherwise 0 -> Q=8'hFF.
  - Swap to 0 only during the cycle S=i, otherwise 1 -> Q=8'h00.
REQ-036 CE stalls: CE toggling 1/0 during a scan with D=8'h3C:
  - Q=8'h3C;
  - DONE pulse lasts exactly one enabled cycle;
  - all outputs frozen while CE=0.
REQ-037 Back-to-back: START held high continuously, D=8'h0F then 8'hF0 for the second scan:
  - two DONE pulses 10 edges apart;
  - Q=8'h0F then 8'hF0;
  - START ignored mid-scan.
REQ-038 Async reset: CLR asserted between edges at S=4 -> outputs reset immediately:
  - Q=QINIT, LO=INIT, no DONE.
  - A new START then gives a correct Q.
REQ-039 Parameters: INIT=1'b1, QINIT=8'h81 -> LO=1, Q=8'h81 after CLR.
  - Q is unchanged until the first completion.
